rr_arbiter_x4: RTL
==================

# rr_arbiter_x4

Four-requester arbiter with a single-cycle turnaround that shares one downstream resource, for example the 4-input priority-encoded datapath, between requesters 0..3. It supports two arbitration modes:
- fixed priority, where the highest index wins, matching the encoder's priority order;
- round-robin.

Each grant is held until the resource signals completion, the requester withdraws, or a hold timeout expires. It sits between the request sources and the shared resource and drives a one-hot grant plus its encoded index.

## Interface
Parameters:
- MAX_HOLD, default 8 — maximum consecutive cycles one grant may stay active; legal range 1..255; the hold counter is 8 bits.

Ports:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — synchronous, active-high; sampled on the rising edge of clk.
- enable  in  1  — 1 allows new grants; 0 blocks new arbitration but does not abort an active grant.
- mode  in  1  — 0 = fixed priority, where req[3] is highest; 1 = round-robin.
- req  in  4  — request vector, one bit per requester; a requester holds its bit high until served.
- done  in  1  — resource reports that the current transaction is complete; single-cycle pulse.
- gnt  out  4  — one-hot grant, registered; all zeros when no grant is active.
- gnt_idx  out  2  — binary index of the current or most recent winner, registered.
- busy  out  1  — 1 while any gnt bit is high; equals |gnt.
- timeout  out  1  — one-cycle pulse when a grant was terminated by MAX_HOLD.

## Operation
- States: IDLE, GRANT, RELEASE. The state register and all outputs are registered.
- Reset values: gnt=0000, gnt_idx=00, busy=0, timeout=0, state=IDLE, rr pointer ptr=3, hold_cnt=0.
- Reset mid-operation: reset overrides everything. On the cycle after reset is sampled, all outputs are at their reset values and any active grant is dropped.
- Arbitration happens in IDLE or RELEASE when enable=1 and req!=0. The winner is loaded into gnt and gnt_idx, and the state moves to GRANT.
- Fixed mode: the winner is the highest set bit of req.
- Round-robin mode:
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set bit wins.
  - On every grant, ptr is set to the winner.
  - ptr is updated in fixed mode too, so a switch to round-robin continues fairly.
- mode and enable are sampled only at arbitration cycles.
- IDLE:
  - enable=0 or req=0: stay in IDLE with gnt=0.
  - Otherwise: arbitrate and go to GRANT.
- GRANT:
  - hold_cnt starts at 1 on the first grant cycle and increments each cycle.
  - Exit to RELEASE on the first cycle any of the following holds:
    - done=1;
    - req[gnt_idx]=0;
    - hold_cnt==MAX_HOLD.
  - In all three cases gnt is cleared on the next edge.
- Timeout rule: timeout=1 during the RELEASE cycle only if the exit cause was hold_cnt==MAX_HOLD with done=0 and req[gnt_idx]=1. When done and the MAX_HOLD limit coincide, done wins and timeout stays 0.
- RELEASE:
  - gnt=0000, busy=0; this is the mandatory one-cycle turnaround.
  - Arbitrate as in IDLE: with a request pending, go to GRANT; otherwise go to IDLE.
  - hold_cnt clears.
- enable falling during GRANT: the grant runs to its normal exit, then no new grant is issued.
- gnt_idx holds the last winner while gnt=0.
- Fixed-mode starvation is permitted by design: after a timeout, the same high-index requester wins again if it is still requesting.

## Timing
- Request-to-grant latency: req sampled high at edge k in IDLE (enable=1) → gnt high after edge k, visible in cycle k+1.
- Back-to-back grants: exactly one cycle with gnt=0 between consecutive grants.
- Hold limit: a grant is high for at most MAX_HOLD cycles. With MAX_HOLD=1 each grant lasts exactly one cycle.
- Release latency: done or req drop sampled at edge k → gnt=0 from cycle k+1.
- A done pulse while in IDLE or RELEASE is ignored.
- gnt is always one-hot or zero; no cycle has two bits set.

## Test plan
- Reset: assert reset with req=1111 mid-grant → next cycle gnt=0000, gnt_idx=00, busy=0, timeout=0; release reset with req=0001, enable=1 → gnt=0001 one cycle later.
- Fixed priority: mode=0, req=0110 held, done pulse every 3rd grant cycle → grants are always gnt=0100 (idx 2), separated by one zero cycle.
- Round-robin fairness: mode=1, req=1111 held, done one cycle after each grant → grant sequence idx 0,1,2,3,0 with one idle cycle between grants.
- Timeout: MAX_HOLD=4, mode=1, req=0011 held, done never → gnt=0001 for 4 cycles, then timeout=1 with gnt=0 for one cycle, then gnt=0010 for 4 cycles.
- Simultaneous events: done=1 on the same cycle hold_cnt==MAX_HOLD → gnt drops, timeout stays 0. req[idx] drops together with done → a single RELEASE cycle.
- Enable gating: enable drops during an active grant → the grant completes on done; later requests with enable=0 get no grant; enable returns to 1 → grant one cycle later.

Source files
------------

// File: rtl/rr_arbiter_x4.sv
// Four-requester arbiter with fixed-priority and round-robin modes, a hold
// timeout, and a mandatory one-cycle turnaround between consecutive grants.
module rr_arbiter_x4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    logic       busy_q, busy_d;

    logic [3:0] rot_req;
    logic [1:0] fix_idx, rr_off, rr_idx, win_idx;
    logic       arb_go, hold_exp, req_live, grant_end;

    // rot_req[gi] is the request of the requester gi+1 places after ptr.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req[2'(ptr_q + 2'(gi + 1))];
    end

    always_comb begin
        fix_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) fix_idx = 2'(i);
        end
    end

    always_comb begin
        rr_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) rr_off = 2'(i);
        end
    end

    assign rr_idx    = ptr_q + 2'd1 + rr_off;
    assign win_idx   = mode ? rr_idx : fix_idx;
    assign arb_go    = enable && (|req);
    assign hold_exp  = (hold_q == MAX_HOLD_C);
    assign req_live  = req[idx_q];
    assign grant_end = done || !req_live || hold_exp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            ptr_q     <= 2'd3;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_RELEASE: state_d = arb_go ? S_GRANT : S_IDLE;
            S_GRANT:           state_d = grant_end ? S_RELEASE : S_GRANT;
            default:           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_GRANT: begin
                if (grant_end) begin
                    gnt_d     = 4'b0000;
                    hold_d    = 8'd0;
                    // done takes precedence over the hold limit
                    timeout_d = hold_exp && !done && req_live;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                gnt_d  = 4'b0000;
                hold_d = 8'd0;
                if (arb_go) begin
                    gnt_d  = 4'b0001 << win_idx;
                    idx_d  = win_idx;
                    ptr_d  = win_idx;
                    hold_d = 8'd1;
                end
            end
        endcase
        busy_d = |gnt_d;
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
